// File: rtl/abr_prim_diff_decode.sv
// Differential pair receiver: decodes p/n rails into a registered level plus
// single-cycle rise/fall/event pulses, and flags rails that carry equal values.
module abr_prim_diff_decode #(
   parameter bit AsyncOn = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       diff_pi,
   input  logic       diff_ni,
   output logic       level_o,
   output logic       rise_o,
   output logic       fall_o,
   output logic       event_o,
   output logic       sigint_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      IsStd     = 2'd0,
      IsSkewing = 2'd1,
      SigInt    = 2'd2
   } state_e;

   state_e state_q;
   logic   level_d, level_q;
   logic   rise, fall, sigint;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) level_q <= 1'b0;
      else         level_q <= level_d;
   end

   if (AsyncOn) begin : gen_async
      state_e state_d;
      logic   p_meta, p_sync, n_meta, n_sync;

      // Synchronizers reset to the valid "0" encoding so release is quiet.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            p_meta <= 1'b0;
            p_sync <= 1'b0;
            n_meta <= 1'b1;
            n_sync <= 1'b1;
         end else begin
            p_meta <= diff_pi;
            p_sync <= p_meta;
            n_meta <= diff_ni;
            n_sync <= n_meta;
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) state_q <= IsStd;
         else         state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            IsStd:     if (p_sync == n_sync) state_d = IsSkewing;
            IsSkewing: state_d = (p_sync != n_sync) ? IsStd : SigInt;
            SigInt:    if (p_sync != n_sync) state_d = IsStd;
            default:   state_d = IsStd;
         endcase
      end

      // Leaving SigInt holds the level; any pending edge pulses one cycle later.
      always_comb begin
         level_d = level_q;
         rise    = 1'b0;
         fall    = 1'b0;
         sigint  = 1'b0;
         unique case (state_q)
            IsStd, IsSkewing: begin
               if (p_sync != n_sync) begin
                  level_d = p_sync;
                  rise    = p_sync & ~level_q;
                  fall    = ~p_sync & level_q;
               end else if (state_q == IsSkewing) begin
                  sigint = 1'b1;
               end
            end
            SigInt:  sigint = (p_sync == n_sync);
            default: sigint = 1'b0;
         endcase
      end
   end else begin : gen_sync
      assign state_q = IsStd;

      always_comb begin
         level_d = level_q;
         rise    = 1'b0;
         fall    = 1'b0;
         sigint  = (diff_pi == diff_ni);
         if (!sigint) begin
            level_d = diff_pi;
            rise    = diff_pi & ~level_q;
            fall    = ~diff_pi & level_q;
         end
      end
   end

   // Pulses and error are masked while reset is held.
   assign level_o  = level_q;
   assign rise_o   = rst_ni & rise;
   assign fall_o   = rst_ni & fall;
   assign event_o  = rst_ni & (rise | fall);
   assign sigint_o = rst_ni & sigint;
   assign state_o  = state_q;

endmodule

// File: tb/tb_abr_prim_diff_decode.sv
// Bench for abr_prim_diff_decode: async and sync instances share the rails and
// are scored every cycle against a rule-level reference model.
module tb_abr_prim_diff_decode;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       diff_p = 1'b0;
   logic       diff_n = 1'b1;

   logic       a_level, a_rise, a_fall, a_event, a_sigint;
   logic [1:0] a_state;
   logic       s_level, s_rise, s_fall, s_event, s_sigint;
   logic [1:0] s_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] exp_a_q[$];
   logic [4:0] exp_s_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   abr_prim_diff_decode #(.AsyncOn(1'b1)) u_async (
      .clk_i(clk), .rst_ni(rst_n), .diff_pi(diff_p), .diff_ni(diff_n),
      .level_o(a_level), .rise_o(a_rise), .fall_o(a_fall), .event_o(a_event),
      .sigint_o(a_sigint), .state_o(a_state)
   );

   abr_prim_diff_decode #(.AsyncOn(1'b0)) u_sync (
      .clk_i(clk), .rst_ni(rst_n), .diff_pi(diff_p), .diff_ni(diff_n),
      .level_o(s_level), .rise_o(s_rise), .fall_o(s_fall), .event_o(s_event),
      .sigint_o(s_sigint), .state_o(s_state)
   );

   // ---------------- reference model ----------------
   // Async: rails seen two edges late; error once rails are equal for two
   // consecutive synced cycles; the first valid cycle after an error only clears it.
   logic p_prev = 1'b0, n_prev = 1'b1, rst_prev = 1'b0;
   logic m_s1p = 1'b0, m_s1n = 1'b1, m_s2p = 1'b0, m_s2n = 1'b1;
   int   m_eq_run = 0, m_eq_cur = 0;
   logic m_err_last = 1'b0, m_err_cur = 1'b0;
   logic m_alevel = 1'b0, m_alevel_d = 1'b0;
   logic m_slevel = 1'b0, m_slevel_d = 1'b0;

   task automatic step(input logic p, input logic n, input logic r);
      logic rise, fall, sig;
      @(posedge clk);
      #1;
      if (rst_prev) begin
         m_s2p      = m_s1p;
         m_s2n      = m_s1n;
         m_s1p      = p_prev;
         m_s1n      = n_prev;
         m_alevel   = m_alevel_d;
         m_eq_run   = m_eq_cur;
         m_err_last = m_err_cur;
         m_slevel   = m_slevel_d;
      end
      diff_p   = p;
      diff_n   = n;
      rst_n    = r;
      p_prev   = p;
      n_prev   = n;
      rst_prev = r;
      if (!r) begin
         m_s1p = 1'b0; m_s1n = 1'b1; m_s2p = 1'b0; m_s2n = 1'b1;
         m_eq_run = 0; m_eq_cur = 0; m_err_last = 1'b0; m_err_cur = 1'b0;
         m_alevel = 1'b0; m_alevel_d = 1'b0;
         m_slevel = 1'b0; m_slevel_d = 1'b0;
         exp_a_q.push_back(5'b0);
         exp_s_q.push_back(5'b0);
      end else begin
         // async instance
         m_eq_cur   = (m_s2p == m_s2n) ? m_eq_run + 1 : 0;
         if (m_eq_cur > 3) m_eq_cur = 3;
         m_err_cur  = (m_eq_cur >= 2);
         m_alevel_d = m_alevel;
         rise = 1'b0; fall = 1'b0;
         if (m_s2p != m_s2n && !m_err_last) begin
            m_alevel_d = m_s2p;
            rise = m_s2p && !m_alevel;
            fall = !m_s2p && m_alevel;
         end
         exp_a_q.push_back({m_alevel, rise, fall, rise | fall, m_err_cur});
         // sync instance
         sig = (p == n);
         m_slevel_d = m_slevel;
         rise = 1'b0; fall = 1'b0;
         if (!sig) begin
            m_slevel_d = p;
            rise = p && !m_slevel;
            fall = !p && m_slevel;
         end
         exp_s_q.push_back({m_slevel, rise, fall, rise | fall, sig});
      end
   endtask

   task automatic hold(input logic p, input logic n, input int cycles);
      for (int i = 0; i < cycles; i++) step(p, n, 1'b1);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [4:0] exp_v, act_v;
      if (exp_a_q.size() > 0) begin
         exp_v = exp_a_q.pop_front();
         act_v = {a_level, a_rise, a_fall, a_event, a_sigint};
         n_checks++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL async_decode t=%0t {level,rise,fall,event,sigint} actual=%b expected=%b",
                     $time, act_v, exp_v);
         end
      end
      if (exp_s_q.size() > 0) begin
         exp_v = exp_s_q.pop_front();
         act_v = {s_level, s_rise, s_fall, s_event, s_sigint};
         n_checks++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL sync_decode t=%0t {level,rise,fall,event,sigint} actual=%b expected=%b",
                     $time, act_v, exp_v);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic rp, rn, rr;
      // reset, then quiet valid 0
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
      hold(1'b0, 1'b1, 10);
      // clean simultaneous toggle to 1
      hold(1'b1, 1'b0, 6);
      hold(1'b0, 1'b1, 5);
      // one-cycle skew on a rising toggle
      step(1'b1, 1'b1, 1'b1);
      hold(1'b1, 1'b0, 5);
      // equal rails for 5 cycles with level 1, then restore valid 0
      hold(1'b1, 1'b1, 5);
      hold(1'b0, 1'b1, 6);
      // sync-mode sequence: 1, fault, 0
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      hold(1'b0, 1'b1, 3);
      // reset asserted while in the fault state with level 1
      hold(1'b1, 1'b0, 5);
      hold(1'b1, 1'b1, 4);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      hold(1'b0, 1'b1, 6);
      // rails toggling every cycle
      for (int i = 0; i < 10; i++) step(i[0], ~i[0], 1'b1);
      // valid 1 at reset release gives one delayed rise
      step(1'b1, 1'b0, 1'b0);
      hold(1'b1, 1'b0, 5);
      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         rp = 1'($urandom_range(0, 1));
         rn = ($urandom_range(0, 4) == 0) ? rp : ~rp;
         rr = ($urandom_range(0, 49) != 0);
         step(rp, rn, rr);
      end
      hold(1'b0, 1'b1, 4);
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_a_q.size() != 0 || exp_s_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain async_left=%0d sync_left=%0d expected=0",
                  exp_a_q.size(), exp_s_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
